// File: rtl/alloc_gen.sv
// Linked-memory heap allocator: bump allocation plus a free-list threaded through
// the cells themselves, with a one-entry link prefetch so free-list allocations run back to back.
module alloc_gen #(
   parameter int unsigned        DATA_SZ = 16,
   parameter int unsigned        ADDR_SZ = 8,
   parameter int unsigned        MEM_MAX = 1 << ADDR_SZ,
   parameter logic [DATA_SZ-1:0] PTR_TAG = 16'h5000,
   parameter logic [DATA_SZ-1:0] UNDEF   = 16'h0000,
   parameter logic [DATA_SZ-1:0] NIL     = 16'h0001
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_alloc,
   input  logic [DATA_SZ-1:0] i_data,
   output logic [DATA_SZ-1:0] o_addr,
   input  logic               i_free,
   input  logic [DATA_SZ-1:0] i_addr,
   input  logic               i_wr,
   input  logic [DATA_SZ-1:0] i_waddr,
   input  logic [DATA_SZ-1:0] i_wdata,
   input  logic               i_rd,
   input  logic [DATA_SZ-1:0] i_raddr,
   output logic [DATA_SZ-1:0] o_rdata,
   output logic               o_err,
   output logic [1:0]         o_err_code,
   output logic [ADDR_SZ:0]   o_free_cnt,
   output logic [ADDR_SZ:0]   o_used_cnt
);

   localparam int unsigned        MW       = (MEM_MAX > 1) ? $clog2(MEM_MAX) : 1;
   localparam logic [ADDR_SZ:0]   CELLS    = (ADDR_SZ+1)'(MEM_MAX);
   localparam logic [DATA_SZ-1:0] IDX_MASK = DATA_SZ'({ADDR_SZ{1'b1}});

   typedef enum logic [1:0] {
      ERR_NONE = 2'd0,
      ERR_PORT = 2'd1,
      ERR_OOM  = 2'd2,
      ERR_PTR  = 2'd3
   } err_e;

   logic [DATA_SZ-1:0] mem [MEM_MAX];
   logic [DATA_SZ-1:0] ram_q;
   logic               ram_we, ram_re;
   logic [MW-1:0]      ram_waddr, ram_raddr;
   logic [DATA_SZ-1:0] ram_wdata;

   logic [ADDR_SZ:0]   top_q, top_d, free_q, free_d, used_q, used_d;
   logic [DATA_SZ-1:0] head_q, head_d, link_q, link_d, addr_q, addr_d;
   logic               link_vld_q, link_vld_d, pf_q, pf_d, rd_q, rd_d, err_q, err_d;
   err_e               code_q, code_d;
   logic [DATA_SZ-1:0] link;
   logic               ptr_req, mem_req;

   function automatic logic ptr_ok(input logic [DATA_SZ-1:0] p, input logic [ADDR_SZ:0] top);
      return ((p & ~IDX_MASK) == PTR_TAG) && ({1'b0, p[ADDR_SZ-1:0]} < top);
   endfunction

   always_comb begin
      ptr_req    = i_alloc | i_free;
      mem_req    = i_rd | i_wr;
      link       = link_vld_q ? link_q : ram_q;
      top_d      = top_q;
      free_d     = free_q;
      used_d     = used_q;
      head_d     = head_q;
      link_d     = link_q;
      link_vld_d = link_vld_q;
      err_d      = err_q;
      code_d     = code_q;
      addr_d     = UNDEF;
      rd_d       = 1'b0;
      pf_d       = 1'b0;
      ram_we     = 1'b0;
      ram_re     = 1'b0;
      ram_waddr  = '0;
      ram_raddr  = '0;
      ram_wdata  = '0;
      // Prefetch capture first; a free or another list allocation this cycle overrides it.
      if (pf_q) begin
         link_d     = ram_q;
         link_vld_d = 1'b1;
      end
      if (!err_q) begin
         if (ptr_req && mem_req) begin
            err_d  = 1'b1;
            code_d = ERR_PORT;
         end else if (ptr_req) begin
            if (i_free && !ptr_ok(i_addr, top_q)) begin
               err_d  = 1'b1;
               code_d = ERR_PTR;
            end else if (i_alloc && i_free) begin
               addr_d    = i_addr;
               ram_we    = 1'b1;
               ram_waddr = i_addr[MW-1:0];
               ram_wdata = i_data;
            end else if (i_alloc && free_q == '0) begin
               if (top_q == CELLS) begin
                  err_d  = 1'b1;
                  code_d = ERR_OOM;
               end else begin
                  addr_d    = PTR_TAG | DATA_SZ'(top_q[ADDR_SZ-1:0]);
                  ram_we    = 1'b1;
                  ram_waddr = top_q[MW-1:0];
                  ram_wdata = i_data;
                  top_d     = top_q + 1'b1;
                  used_d    = used_q + 1'b1;
               end
            end else if (i_alloc) begin
               addr_d     = head_q;
               ram_we     = 1'b1;
               ram_waddr  = head_q[MW-1:0];
               ram_wdata  = i_data;
               head_d     = link;
               free_d     = free_q - 1'b1;
               used_d     = used_q + 1'b1;
               ram_re     = 1'b1;
               ram_raddr  = link[MW-1:0];
               link_vld_d = 1'b0;
               pf_d       = 1'b1;
            end else begin
               ram_we     = 1'b1;
               ram_waddr  = i_addr[MW-1:0];
               ram_wdata  = head_q;
               link_d     = head_q;
               link_vld_d = 1'b1;
               head_d     = i_addr;
               free_d     = free_q + 1'b1;
               used_d     = used_q - 1'b1;
            end
         end else if (mem_req) begin
            if ((i_rd && !ptr_ok(i_raddr, top_q)) || (i_wr && !ptr_ok(i_waddr, top_q))) begin
               err_d  = 1'b1;
               code_d = ERR_PTR;
            end else begin
               if (i_rd) begin
                  ram_re    = 1'b1;
                  ram_raddr = i_raddr[MW-1:0];
                  rd_d      = 1'b1;
               end
               if (i_wr) begin
                  ram_we    = 1'b1;
                  ram_waddr = i_waddr[MW-1:0];
                  ram_wdata = i_wdata;
               end
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         top_q      <= '0;
         free_q     <= '0;
         used_q     <= '0;
         head_q     <= NIL;
         link_q     <= NIL;
         link_vld_q <= 1'b0;
         pf_q       <= 1'b0;
         addr_q     <= UNDEF;
         rd_q       <= 1'b0;
         err_q      <= 1'b0;
         code_q     <= ERR_NONE;
      end else begin
         top_q      <= top_d;
         free_q     <= free_d;
         used_q     <= used_d;
         head_q     <= head_d;
         link_q     <= link_d;
         link_vld_q <= link_vld_d;
         pf_q       <= pf_d;
         addr_q     <= addr_d;
         rd_q       <= rd_d;
         err_q      <= err_d;
         code_q     <= code_d;
      end
   end

   // Read-before-write RAM; contents survive reset.
   always_ff @(posedge i_clk) begin
      if (ram_re && !i_rst) ram_q <= mem[ram_raddr];
      if (ram_we && !i_rst) mem[ram_waddr] <= ram_wdata;
   end

   assign o_addr     = addr_q;
   assign o_rdata    = rd_q ? ram_q : UNDEF;
   assign o_err      = err_q;
   assign o_err_code = code_q;
   assign o_free_cnt = free_q;
   assign o_used_cnt = used_q;

endmodule

// File: tb/tb_alloc_gen.sv
// Bench for alloc_gen: directed vector table, hand-written free-list sequences,
// and randomized traffic checked against a queue-based heap model.
module tb_alloc_gen;

   localparam logic [15:0] TAG = 16'h5000;
   localparam logic [15:0] NIL = 16'h0001;

   logic        clk = 1'b0;
   logic        rst, alloc, free, wr, rd;
   logic [15:0] data, addr, waddr, wdata, raddr;
   logic [15:0] o_addr, o_rdata, s_addr, s_rdata;
   logic        o_err, s_err;
   logic [1:0]  o_code, s_code;
   logic [8:0]  o_free, o_used, s_free, s_used;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   always #5 clk = ~clk;

   alloc_gen #(.DATA_SZ(16), .ADDR_SZ(8)) dut (
      .i_clk(clk), .i_rst(rst), .i_alloc(alloc), .i_data(data), .o_addr(o_addr),
      .i_free(free), .i_addr(addr), .i_wr(wr), .i_waddr(waddr), .i_wdata(wdata),
      .i_rd(rd), .i_raddr(raddr), .o_rdata(o_rdata), .o_err(o_err),
      .o_err_code(o_code), .o_free_cnt(o_free), .o_used_cnt(o_used)
   );

   alloc_gen #(.DATA_SZ(16), .ADDR_SZ(8), .MEM_MAX(4)) dut4 (
      .i_clk(clk), .i_rst(rst), .i_alloc(alloc), .i_data(data), .o_addr(s_addr),
      .i_free(free), .i_addr(addr), .i_wr(wr), .i_waddr(waddr), .i_wdata(wdata),
      .i_rd(rd), .i_raddr(raddr), .o_rdata(s_rdata), .o_err(s_err),
      .o_err_code(s_code), .o_free_cnt(s_free), .o_used_cnt(s_used)
   );

   typedef struct {
      bit          rst, alloc, free, wr, rd;
      logic [15:0] data, addr, waddr, wdata, raddr;
      logic [15:0] e_addr, e_rdata;
      bit          e_err;
      logic [1:0]  e_code;
      logic [8:0]  e_free, e_used;
   } vec_t;

   vec_t tbl [$];

   function automatic vec_t v(input bit r, a, f, w, d,
                              input logic [15:0] dat, ad, wa, wd, ra, ea, er,
                              input bit ee, input logic [1:0] ec, input int unsigned ef, eu);
      vec_t t;
      t.rst = r; t.alloc = a; t.free = f; t.wr = w; t.rd = d;
      t.data = dat; t.addr = ad; t.waddr = wa; t.wdata = wd; t.raddr = ra;
      t.e_addr = ea; t.e_rdata = er; t.e_err = ee; t.e_code = ec;
      t.e_free = 9'(ef); t.e_used = 9'(eu);
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic idle_in();
      rst = 0; alloc = 0; free = 0; wr = 0; rd = 0;
      data = '0; addr = '0; waddr = '0; wdata = '0; raddr = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_rst();   idle_in(); rst = 1; tick(); endtask
   task automatic do_alloc(input logic [15:0] d); idle_in(); alloc = 1; data = d; tick(); endtask
   task automatic do_free(input logic [15:0] p);  idle_in(); free = 1; addr = p; tick(); endtask
   task automatic do_rd(input logic [15:0] p);    idle_in(); rd = 1; raddr = p; tick(); endtask

   // ---------------- reference model ----------------
   logic [15:0] mmem [256];
   logic [15:0] fl [$];          // free-list, front = next cell handed out
   int unsigned mtop;
   bit          merr;
   logic [1:0]  mcode;

   function automatic bit m_ok(input logic [15:0] p, input int unsigned top);
      return ((p & 16'hFF00) == TAG) && (int'(p & 16'h00FF) < int'(top));
   endfunction

   function automatic bit is_free(input logic [15:0] p);
      foreach (fl[j]) if (fl[j] == p) return 1'b1;
      return 1'b0;
   endfunction

   task automatic pick_alloc(output bit ok, output logic [15:0] p);
      ok = 1'b0;
      p  = '0;
      for (int t = 0; t < 8 && !ok && mtop > 0; t++) begin
         p  = TAG | 16'($urandom_range(0, mtop - 1));
         ok = !is_free(p);
      end
   endtask

   task automatic model_step(output logic [15:0] ea, output logic [15:0] er);
      ea = 16'h0;
      er = 16'h0;
      if (rst) begin
         fl.delete(); mtop = 0; merr = 0; mcode = 0;
      end else if (!merr) begin
         if ((alloc || free) && (rd || wr)) begin
            merr = 1; mcode = 2'd1;
         end else if (alloc || free) begin
            if (free && !m_ok(addr, mtop)) begin
               merr = 1; mcode = 2'd3;
            end else if (alloc && free) begin
               ea = addr; mmem[addr[7:0]] = data;
            end else if (alloc) begin
               if (fl.size() != 0) begin
                  ea = fl.pop_front(); mmem[ea[7:0]] = data;
               end else if (mtop == 256) begin
                  merr = 1; mcode = 2'd2;
               end else begin
                  ea = TAG | 16'(mtop); mmem[mtop] = data; mtop++;
               end
            end else begin
               mmem[addr[7:0]] = (fl.size() != 0) ? fl[0] : NIL;
               fl.push_front(addr);
            end
         end else if (rd || wr) begin
            if ((rd && !m_ok(raddr, mtop)) || (wr && !m_ok(waddr, mtop))) begin
               merr = 1; mcode = 2'd3;
            end else begin
               if (rd) er = mmem[raddr[7:0]];
               if (wr) mmem[waddr[7:0]] = wdata;
            end
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit          ok;
      logic [15:0] p, ea, er;
      int unsigned k, err_age;

      idle_in();

      //           r a f w d  data      addr      waddr     wdata     raddr      e_addr    e_rdata  e c fr us
      tbl.push_back(v(1,0,0,0,0, 16'h0,    16'h0,    16'h0,    16'h0,    16'h0,     16'h0,    16'h0,   0,0,0,0));
      tbl.push_back(v(0,1,0,0,0, 16'h8001, 16'h0,    16'h0,    16'h0,    16'h0,     16'h5000, 16'h0,   0,0,0,1));
      tbl.push_back(v(0,1,0,0,0, 16'h8002, 16'h0,    16'h0,    16'h0,    16'h0,     16'h5001, 16'h0,   0,0,0,2));
      tbl.push_back(v(0,1,0,0,0, 16'h8003, 16'h0,    16'h0,    16'h0,    16'h0,     16'h5002, 16'h0,   0,0,0,3));
      tbl.push_back(v(0,0,1,0,0, 16'h0,    16'h5001, 16'h0,    16'h0,    16'h0,     16'h0,    16'h0,   0,0,1,2));
      tbl.push_back(v(0,0,1,0,0, 16'h0,    16'h5000, 16'h0,    16'h0,    16'h0,     16'h0,    16'h0,   0,0,2,1));
      tbl.push_back(v(0,1,0,0,0, 16'h9001, 16'h0,    16'h0,    16'h0,    16'h0,     16'h5000, 16'h0,   0,0,1,2));
      tbl.push_back(v(0,1,0,0,0, 16'h9002, 16'h0,    16'h0,    16'h0,    16'h0,     16'h5001, 16'h0,   0,0,0,3));
      tbl.push_back(v(0,0,0,0,1, 16'h0,    16'h0,    16'h0,    16'h0,    16'h5000,  16'h0,    16'h9001,0,0,0,3));
      tbl.push_back(v(0,1,1,0,0, 16'h7777, 16'h5002, 16'h0,    16'h0,    16'h0,     16'h5002, 16'h0,   0,0,0,3));
      tbl.push_back(v(0,0,0,1,0, 16'h0,    16'h0,    16'h5001, 16'h1234, 16'h0,     16'h0,    16'h0,   0,0,0,3));
      tbl.push_back(v(0,0,0,0,1, 16'h0,    16'h0,    16'h0,    16'h0,    16'h5001,  16'h0,    16'h1234,0,0,0,3));
      tbl.push_back(v(0,0,0,0,0, 16'h0,    16'h0,    16'h0,    16'h0,    16'h0,     16'h0,    16'h0,   0,0,0,3));
      tbl.push_back(v(0,0,0,0,1, 16'h0,    16'h0,    16'h0,    16'h0,    16'h5002,  16'h0,    16'h7777,0,0,0,3));
      tbl.push_back(v(0,0,0,1,1, 16'h0,    16'h0,    16'h5000, 16'hABCD, 16'h5000,  16'h0,    16'h9001,0,0,0,3));
      tbl.push_back(v(0,0,0,0,1, 16'h0,    16'h0,    16'h0,    16'h0,    16'h5000,  16'h0,    16'hABCD,0,0,0,3));
      tbl.push_back(v(0,1,0,0,1, 16'h1111, 16'h0,    16'h0,    16'h0,    16'h5000,  16'h0,    16'h0,   1,1,0,3));
      tbl.push_back(v(0,1,0,0,0, 16'h1111, 16'h0,    16'h0,    16'h0,    16'h0,     16'h0,    16'h0,   1,1,0,3));
      tbl.push_back(v(1,0,0,0,0, 16'h0,    16'h0,    16'h0,    16'h0,    16'h0,     16'h0,    16'h0,   0,0,0,0));
      tbl.push_back(v(0,0,1,0,0, 16'h0,    16'h4000, 16'h0,    16'h0,    16'h0,     16'h0,    16'h0,   1,3,0,0));
      tbl.push_back(v(1,0,0,0,0, 16'h0,    16'h0,    16'h0,    16'h0,    16'h0,     16'h0,    16'h0,   0,0,0,0));
      tbl.push_back(v(0,1,0,0,0, 16'h2222, 16'h0,    16'h0,    16'h0,    16'h0,     16'h5000, 16'h0,   0,0,0,1));
      tbl.push_back(v(0,1,0,0,0, 16'h3333, 16'h0,    16'h0,    16'h0,    16'h0,     16'h5001, 16'h0,   0,0,0,2));
      tbl.push_back(v(0,0,0,0,1, 16'h0,    16'h0,    16'h0,    16'h0,    16'h5007,  16'h0,    16'h0,   1,3,0,2));
      tbl.push_back(v(1,0,0,0,0, 16'h0,    16'h0,    16'h0,    16'h0,    16'h0,     16'h0,    16'h0,   0,0,0,0));
      tbl.push_back(v(0,1,0,0,0, 16'h4444, 16'h0,    16'h0,    16'h0,    16'h0,     16'h5000, 16'h0,   0,0,0,1));
      tbl.push_back(v(0,0,0,1,0, 16'h0,    16'h0,    16'h5001, 16'h5555, 16'h0,     16'h0,    16'h0,   1,3,0,1));

      foreach (tbl[i]) begin
         rst = tbl[i].rst; alloc = tbl[i].alloc; free = tbl[i].free; wr = tbl[i].wr; rd = tbl[i].rd;
         data = tbl[i].data; addr = tbl[i].addr; waddr = tbl[i].waddr;
         wdata = tbl[i].wdata; raddr = tbl[i].raddr;
         tick();
         check($sformatf("vec%0d_addr", i),  32'(o_addr),  32'(tbl[i].e_addr));
         check($sformatf("vec%0d_rdata", i), 32'(o_rdata), 32'(tbl[i].e_rdata));
         check($sformatf("vec%0d_err", i),   32'(o_err),   32'(tbl[i].e_err));
         check($sformatf("vec%0d_code", i),  32'(o_code),  32'(tbl[i].e_code));
         check($sformatf("vec%0d_free", i),  32'(o_free),  32'(tbl[i].e_free));
         check($sformatf("vec%0d_used", i),  32'(o_used),  32'(tbl[i].e_used));
      end

      // Three-deep free-list burst: list 5000 -> 5001 -> 5003.
      do_rst();
      for (int i = 0; i < 4; i++) begin
         do_alloc(16'hA000 + 16'(i));
         check($sformatf("burst_fill%0d", i), 32'(o_addr), 32'(TAG + 16'(i)));
      end
      do_free(16'h5003); do_free(16'h5001); do_free(16'h5000);
      check("burst_free_cnt", 32'(o_free), 32'd3);
      do_alloc(16'hB000); check("burst_a0", 32'(o_addr), 32'h5000);
      do_alloc(16'hB001); check("burst_a1", 32'(o_addr), 32'h5001);
      do_alloc(16'hB002); check("burst_a2", 32'(o_addr), 32'h5003);
      do_alloc(16'hB003); check("burst_a3", 32'(o_addr), 32'h5004);
      check("burst_free0", 32'(o_free), 32'd0);
      check("burst_used5", 32'(o_used), 32'd5);

      // Prefetch must be captured even when a memory read follows the list allocation.
      do_free(16'h5000); do_free(16'h5001);
      do_alloc(16'hC000); check("pf_a0", 32'(o_addr), 32'h5001);
      do_rd(16'h5002);    check("pf_rd", 32'(o_rdata), 32'hA002);
      do_alloc(16'hC001); check("pf_a1", 32'(o_addr), 32'h5000);
      do_alloc(16'hC002); check("pf_a2", 32'(o_addr), 32'h5005);
      do_rd(16'h5001);    check("pf_rd1", 32'(o_rdata), 32'hC000);
      do_rd(16'h5000);    check("pf_rd0", 32'(o_rdata), 32'hC001);

      // Out-of-memory on the four-cell instance.
      do_rst();
      for (int i = 0; i < 4; i++) begin
         do_alloc(16'hD000 + 16'(i));
         check($sformatf("oom_fill%0d", i), 32'(s_addr), 32'(TAG + 16'(i)));
      end
      do_alloc(16'hD004);
      check("oom_addr", 32'(s_addr), 32'h0);
      check("oom_err",  32'(s_err),  32'd1);
      check("oom_code", 32'(s_code), 32'd2);
      do_free(16'h5000);
      check("oom_free_ignored", 32'(s_free), 32'd0);
      check("oom_used_frozen",  32'(s_used), 32'd4);
      do_rst();
      check("oom_rst_err",  32'(s_err),  32'd0);
      check("oom_rst_code", 32'(s_code), 32'd0);
      do_alloc(16'hD005);
      check("oom_after_rst", 32'(s_addr), 32'h5000);

      // Randomized traffic against the model.
      idle_in();
      rst = 1;
      model_step(ea, er);
      tick();
      err_age = 0;
      for (int c = 0; c < 3000; c++) begin
         idle_in();
         if (merr) err_age++; else err_age = 0;
         if (err_age > 3 || $urandom_range(0, 199) == 0) begin
            rst = 1;
         end else begin
            k = $urandom_range(0, 19);
            data  = 16'($urandom);
            wdata = 16'($urandom);
            if (k < 7) begin
               alloc = 1;
            end else if (k < 11) begin
               pick_alloc(ok, p);
               if (ok) begin free = 1; addr = p; end else alloc = 1;
            end else if (k < 12) begin
               pick_alloc(ok, p);
               if (ok) begin alloc = 1; free = 1; addr = p; end
            end else if (k < 15) begin
               if (mtop > 0) begin rd = 1; raddr = TAG | 16'($urandom_range(0, mtop - 1)); end
            end else if (k < 17) begin
               pick_alloc(ok, p);
               if (ok) begin wr = 1; waddr = p; end
            end else if (k < 19) begin
               pick_alloc(ok, p);
               if (ok) begin wr = 1; waddr = p; rd = 1; raddr = p; end
            end else if ($urandom_range(0, 3) == 0) begin
               case ($urandom_range(0, 2))
                  0: begin alloc = 1; rd = 1; raddr = TAG; end
                  1: begin free = 1; addr = 16'h4000 | 16'($urandom_range(0, 255)); end
                  default: begin rd = 1; raddr = TAG | 16'(mtop + $urandom_range(0, 3)); end
               endcase
            end
         end
         model_step(ea, er);
         tick();
         check("rnd_addr",  32'(o_addr),  32'(ea));
         check("rnd_rdata", 32'(o_rdata), 32'(er));
         check("rnd_err",   32'(o_err),   32'(merr));
         check("rnd_code",  32'(o_code),  32'(mcode));
         check("rnd_free",  32'(o_free),  32'(fl.size()));
         check("rnd_used",  32'(o_used),  32'(mtop - fl.size()));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alloc_gen.md
Name: alloc_gen

Overview:
- Parametrised linked-memory heap allocator; next generation of the single-width 16-bit allocator.
- Adds synchronous reset, parametrised pointer tagging, and a free-list link prefetch so back-to-back free-list allocations run at full rate.
- Adds pointer bounds checking, an error code, and occupancy counters.
- Sits between the actor/cell machinery and an internal inferred block RAM. All results appear one cycle after the request.

Parameters:
- DATA_SZ, 16: bits per memory word and per pointer.
- ADDR_SZ, 8: bits of cell index; heap holds up to MEM_MAX cells.
- MEM_MAX, 1<<ADDR_SZ: physical cells available, <= 2**ADDR_SZ.
- PTR_TAG, 16'h5000: fixed upper bits (MUT|VLT) ORed onto every allocated index; bits [ADDR_SZ-1:0] must be 0.
- UNDEF, 16'h0000: value driven on idle outputs.
- NIL, 16'h0001: free-list terminator.

Ports:
- i_clk  in  1  domain clock
- i_rst  in  1  synchronous, active-high reset
- i_alloc  in  1  allocation request
- i_data  in  DATA_SZ  initial contents of allocated cell
- o_addr  out  DATA_SZ  allocated pointer, valid the cycle after i_alloc
- i_free  in  1  free request
- i_addr  in  DATA_SZ  pointer being freed
- i_wr  in  1  write request
- i_waddr  in  DATA_SZ  write pointer
- i_wdata  in  DATA_SZ  write data
- i_rd  in  1  read request
- i_raddr  in  DATA_SZ  read pointer
- o_rdata  out  DATA_SZ  read data, valid the cycle after i_rd
- o_err  out  1  sticky error/halt flag
- o_err_code  out  2  0 none, 1 port conflict, 2 out of memory, 3 bad pointer
- o_free_cnt  out  ADDR_SZ+1  cells on free-list
- o_used_cnt  out  ADDR_SZ+1  cells currently allocated

Behaviour:
- Reset (i_rst=1 at an edge; overrides everything):
  - o_addr=UNDEF, o_rdata=UNDEF, o_err=0, o_err_code=0, counters=0.
  - top index=0, head=NIL, link_valid=0.
  - RAM contents are not cleared.
- Output defaults: o_addr and o_rdata return to UNDEF on every cycle without a matching request.
- Port classes:
  - Pointer op: (i_alloc|i_free) and not (i_rd|i_wr).
  - Memory op: the converse.
  - Both classes in one cycle: err 1.
  - Neither: idle.
- Valid pointer: (p & ~index mask) == PTR_TAG and index < top. Any free, rd or wr with an invalid pointer gives err 3 and no RAM write.
- Error:
  - On error, o_err=1 and o_err_code is latched on the next edge.
  - Once o_err=1: all requests ignored, no RAM writes, counters frozen, until i_rst.
  - The errored request's outputs stay UNDEF.
- Alloc and free in the same cycle (pass-through):
  - o_addr=i_addr; RAM[i_addr]<=i_data.
  - Counters and head unchanged.
- Alloc only, free-list empty (free_cnt==0):
  - If top==MEM_MAX: err 2.
  - Else o_addr=PTR_TAG|top, RAM[top]<=i_data, top++, used++.
- Alloc only, free-list non-empty:
  - o_addr=head, RAM[head]<=i_data, head<=link, free--, used++.
  - link = link_valid ? link_reg : RAM read output.
  - Same cycle: issue RAM read of the new head and clear link_valid.
  - Next cycle: link_reg<=RAM read output and link_valid<=1, unconditionally. This is true even if that cycle is a memory op, because the RAM output still holds the prefetch.
  - Result: consecutive free-list allocations need no stall.
- Free only:
  - RAM[i_addr]<=head, link_reg<=head, link_valid<=1, head<=i_addr, free++, used--.
  - Double free is not detected.
- Read: o_rdata=RAM[i_raddr] on the next cycle.
- Write: RAM[i_waddr]<=i_wdata.
- Read and write in the same cycle: allowed. The read returns the old contents.
- Write then read of the same address on the next cycle returns the new data.
- Arithmetic:
  - Counters are ADDR_SZ+1 bits and never wrap.
  - free_cnt+used_cnt==top at all times when o_err=0.

Test Plan:
- Reset, then 3 allocs with i_data=0x8001,0x8002,0x8003 -> o_addr=0x5000,0x5001,0x5002 on consecutive cycles; used=3, free=0.
- Free 0x5001, then free 0x5000, then alloc, alloc on back-to-back cycles -> o_addr=0x5000 then 0x5001 with no gap; read 0x5000 -> 0x8001-style i_data of the new alloc; free=0.
- Alloc+free of 0x5002 in the same cycle -> o_addr=0x5002 next cycle; counters unchanged.
- Write 0x5001<=0x1234, read 0x5001 next cycle -> o_rdata=0x1234 one cycle later; UNDEF on the following idle cycle.
- MEM_MAX=4: 4 allocs succeed, 5th -> o_err=1, code 2; a later free is ignored (free_cnt stays 0); assert i_rst -> o_err=0, code 0, next alloc -> 0x5000.
- i_alloc with i_rd in one cycle -> code 1. After reset, free of 0x4000 -> code 3. After reset, read of 0x5007 when top=2 -> code 3.
